// File: rtl/fir_ctrl_pkg.sv
// Shared FIR controller definitions: tap sequencer state encoding and the
// default tap count used by the coefficient counter, the tap counter and the
// filter controller.
package fir_ctrl_pkg;

  // Default maximum number of taps in one filter run.
  localparam int COUNT_NUM_DEFAULT = 64;

  // Tap sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tap_state_t;

endpackage : fir_ctrl_pkg

// File: rtl/tap_down_counter.sv
// Down-counting tap sequencer. Issues tap indices len-1 .. 0 through a
// valid/ready handshake, then pulses done. Walks the sample history
// newest-to-oldest, the reverse of the coefficient counter.
module tap_down_counter
  import fir_ctrl_pkg::*;
#(
  parameter  int COUNT_NUM = COUNT_NUM_DEFAULT,
  localparam int IDX_W     = $clog2(COUNT_NUM),
  localparam int LEN_W     = $clog2(COUNT_NUM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             busy,
  output logic             done,
  output logic             Bo
);

  tap_state_t       state;
  tap_state_t       state_next;
  logic [IDX_W-1:0] count;
  logic [IDX_W-1:0] count_next;
  logic [LEN_W-1:0] len_sat;
  logic [IDX_W-1:0] load_count;

  // Lengths above the tap capacity saturate so a run never exceeds COUNT_NUM.
  assign len_sat    = (len > LEN_W'(COUNT_NUM)) ? LEN_W'(COUNT_NUM) : len;
  // Only used when len is non-zero, so len_sat - 1 never underflows.
  assign load_count = IDX_W'(len_sat - LEN_W'(1));

  // State and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block using the pre-edge values, regardless of statement order.
      state <= state_next;
      count <= count_next;
    end
  end

  // Next-state and next-count decode from the handshake and control inputs.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch
    // is inferred.
    state_next = state;
    count_next = count;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            count_next = load_count;
          end
        end
      end
      RUN: begin
        // Abort wins over a transfer presented in the same cycle.
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
        end else if (idx_ready) begin
          if (count == '0) begin
            state_next = DONE;
          end else begin
            count_next = count - IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Outputs are pure decodes of registered state; idx_ready and start never
  // reach an output combinationally.
  assign idx_valid = (state == RUN);
  assign idx       = idx_valid ? count : '0;
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);
  assign Bo        = idx_valid && (count == '0);

endmodule : tap_down_counter

// File: tb/tb_tap_down_counter.sv
// Directed self-checking bench for tap_down_counter.
module tb_tap_down_counter;

  localparam int COUNT_NUM = 64;
  localparam int IDX_W     = $clog2(COUNT_NUM);
  localparam int LEN_W     = $clog2(COUNT_NUM + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             idx_ready;
  logic             busy;
  logic             done;
  logic             Bo;

  int checks = 0;
  int errors = 0;

  tap_down_counter #(.COUNT_NUM(COUNT_NUM)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .busy      (busy),
    .done      (done),
    .Bo        (Bo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idx"},   32'(idx),       0);
    check({tag, "_valid"}, 32'(idx_valid), 0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_done"},  32'(done),      0);
    check({tag, "_bo"},    32'(Bo),        0);
  endtask

  // Start a run of len_in taps and expect n_exp indices n_exp-1 .. 0.
  // toggle: idx_ready alternates 1,0,1,0... ; poke: start pulsed mid-run.
  task automatic do_run(input string tag, input int len_in, input int n_exp,
                        input bit toggle, input bit poke);
    int  exp_idx;
    int  xfers;
    int  cyc;
    bit  fin;
    start     = 1'b1;
    len       = LEN_W'(len_in);
    idx_ready = 1'b0;
    step();
    start   = 1'b0;
    exp_idx = n_exp - 1;
    xfers   = 0;
    fin     = (n_exp == 0);
    cyc     = 0;
    while (!fin && cyc < 400) begin
      idx_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (poke && cyc == 2) begin
        start = 1'b1;
        len   = LEN_W'(3);
      end else begin
        start = 1'b0;
      end
      check({tag, "_valid"}, 32'(idx_valid), 1);
      check({tag, "_idx"},   32'(idx),       32'(exp_idx));
      check({tag, "_bo"},    32'(Bo),        32'(exp_idx == 0));
      check({tag, "_busy"},  32'(busy),      1);
      check({tag, "_done"},  32'(done),      0);
      step();
      if (idx_ready) begin
        xfers++;
        if (exp_idx == 0) fin = 1'b1;
        else exp_idx--;
      end
      cyc++;
    end
    idx_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_xfers"},      32'(xfers),     32'(n_exp));
    check({tag, "_done_pulse"}, 32'(done),      1);
    check({tag, "_done_busy"},  32'(busy),      1);
    check({tag, "_done_valid"}, 32'(idx_valid), 0);
    check({tag, "_done_bo"},    32'(Bo),        0);
    step();
    check_idle({tag, "_after"});
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    len       = '0;
    abort     = 1'b0;
    idx_ready = 1'b0;
    step();
    step();
    check_idle("reset");
    reset = 1'b1;
    step();
    check_idle("idle");

    // Basic run, consumer always ready: 3,2,1,0 then done, busy for 5 cycles.
    do_run("len4", 4, 4, 1'b0, 1'b0);
    // Stalling consumer: each index held until accepted.
    do_run("len4_toggle", 4, 4, 1'b1, 1'b0);
    // Zero length: done and busy for one cycle, no index.
    do_run("len0", 0, 0, 1'b0, 1'b0);
    // Over-length saturates to 64 taps; mid-run start ignored.
    do_run("len70", 70, 64, 1'b0, 1'b1);
    // Exact capacity.
    do_run("len64", 64, 64, 1'b0, 1'b0);
    // Single tap.
    do_run("len1", 1, 1, 1'b0, 1'b0);

    // Abort in IDLE is ignored: start alongside abort still launches a run.
    start = 1'b1;
    len   = LEN_W'(1);
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_valid", 32'(idx_valid), 1);
    check("idle_abort_idx",   32'(idx),       0);
    check("idle_abort_bo",    32'(Bo),        1);
    idx_ready = 1'b1;
    step();
    idx_ready = 1'b0;
    check("idle_abort_done", 32'(done), 1);
    step();
    check_idle("idle_abort_after");

    // Abort with a simultaneous ready at idx=2 of a len=5 run.
    start = 1'b1;
    len   = LEN_W'(5);
    step();
    start     = 1'b0;
    idx_ready = 1'b1;
    check("abort_idx4", 32'(idx), 4);
    step();
    check("abort_idx3", 32'(idx), 3);
    step();
    check("abort_idx2", 32'(idx), 2);
    abort = 1'b1;
    step();
    abort     = 1'b0;
    idx_ready = 1'b0;
    check_idle("abort_next");
    step();
    check("abort_no_done", 32'(done), 0);
    do_run("post_abort", 2, 2, 1'b0, 1'b0);

    // Reset asserted mid-run at idx=5 of a len=8 run.
    start = 1'b1;
    len   = LEN_W'(8);
    step();
    start     = 1'b0;
    idx_ready = 1'b1;
    step();
    step();
    check("rst_mid_idx5", 32'(idx), 5);
    #2;
    reset = 1'b0;
    #1;
    check_idle("rst_mid");
    idx_ready = 1'b0;
    step();
    check_idle("rst_hold");
    reset = 1'b1;
    step();
    check_idle("rst_release");
    do_run("post_reset", 3, 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tap_down_counter

// File: doc/tap_down_counter.md
# tap_down_counter

Programmable down-counting tap sequencer for the FIR datapath. After a start request it issues tap indices from `len-1` down to 0 through a valid/ready handshake, stalling whenever the consumer is not ready. It then pulses `done`. It is the reverse-order companion of the up-counting coefficient counter: sample-history addressing walks the taps newest-to-oldest while coefficients walk oldest-to-newest.

## Interface
Parameters:
- `COUNT_NUM`, default 64: maximum number of taps in one run.
- `IDX_W`, default `$clog2(COUNT_NUM)`: width of the index output. Local parameter, not overridable.
- `LEN_W`, default `$clog2(COUNT_NUM+1)`: width of the length input. Local parameter, not overridable.

Ports:
- `clk` input 1: the single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a run. Sampled only in IDLE.
- `len` input `LEN_W`: number of taps to issue. Sampled on an accepted `start`.
- `abort` input 1: cancel the run in progress.
- `idx` output `IDX_W`: current tap index.
- `idx_valid` output 1: `idx` is valid.
- `idx_ready` input 1: the consumer accepts `idx` this cycle.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: single-cycle pulse when a run completes normally.
- `Bo` output 1: borrow flag. High while the last index (0) is being presented.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, internal count 0, and drives every output low.
- IDLE:
  - `start=1` with `len` from 1 to `COUNT_NUM`: load count = `len-1`, go to RUN.
  - `len` greater than `COUNT_NUM`: saturate to `COUNT_NUM`, so the count loads `COUNT_NUM-1`.
  - `start=1` with `len=0`: go directly to DONE. No index is issued.
- RUN:
  - `idx_valid=1` and `idx`=count.
  - A transfer occurs on a cycle with `idx_valid && idx_ready`.
  - On a transfer with count > 0: decrement the count.
  - On a transfer with count = 0: go to DONE.
  - With `idx_ready=0`: `idx` and `idx_valid` hold stable. No index is ever skipped or repeated.
- DONE: `done=1` for exactly one cycle, then go to IDLE.
- `abort` in RUN has priority over a simultaneous transfer. Go to IDLE and clear the count. No `done` pulse. `idx_valid` low from the next cycle.
- `abort` in IDLE or DONE is ignored.
- `start` while `busy` is ignored. It is not queued.
- `Bo` = `idx_valid && (count == 0)`. It is combinational from registered state.
- Count arithmetic is unsigned `IDX_W` bits. The count never decrements below 0, so there is no wrap-around.
- Reset asserted mid-run returns the block immediately to IDLE with all outputs low. The interrupted run is lost.

## Timing
- Start accepted at edge k: `idx_valid` and `busy` are high after edge k. The first index is presented in cycle k+1.
- With `idx_ready` held high: one index per cycle. `len` indices occupy cycles k+1 to k+len. `done` is high in cycle k+len+1. `busy` falls after that cycle.
- `len=0`: `done` and `busy` are high in cycle k+1 only.
- Minimum start-to-start spacing is `len+2` cycles.
- A new `start` is accepted in the first IDLE cycle after DONE.
- All outputs are registered-state decodes. There is no combinational path from `idx_ready` or `start` to any output.

## Structure
- Shared package `fir_ctrl_pkg` holds:
  - the state typedef `tap_state_t` (IDLE, RUN, DONE);
  - the default `COUNT_NUM` constant, shared with the coefficient counter and the filter controller.
- Single module with no sub-module. The down-counter and the FSM are small enough to live together. Separating them adds ports without adding reuse.

## Test plan
- Reset, then `start`, `len=4`, `idx_ready=1` -> `idx` = 3,2,1,0 on consecutive cycles. `Bo` is high only with `idx=0`. `done` is pulsed one cycle later. `busy` is high for 5 cycles.
- `len=4` with `idx_ready` toggling 1,0,1,0,… -> each index is held while not ready. Exactly 3,2,1,0 are transferred. `done` follows the final transfer by one cycle.
- `len=0` -> no `idx_valid`. `done` and `busy` are high for one cycle.
- `len=70` with `COUNT_NUM=64` -> the first `idx` is 63 and 64 transfers occur. A `start` during RUN is ignored.
- `abort` asserted together with `idx_ready` while `idx=2` (`len=5`) -> no transfer is counted. `idx_valid` and `busy` are low next cycle. No `done`. A following `start` with `len=2` yields 1,0.
- `reset` driven low mid-run at `idx=5` -> all outputs go low immediately. After release the block is in IDLE and accepts a new `start`.
